// File: rtl/dm_bus_responder_pkg.sv
// Shared definitions for the data-bus responder: FSM encodings, byte-enable constants,
// wait-state limit, latched request record and the address range check.
package dm_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam logic [3:0] BE_HALF0 = 4'h3;
  localparam logic [3:0] BE_HALF1 = 4'hC;
  localparam logic [3:0] BE_B0    = 4'h1;
  localparam logic [3:0] BE_B1    = 4'h2;
  localparam logic [3:0] BE_B2    = 4'h4;
  localparam logic [3:0] BE_B3    = 4'h8;

  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err;
  } req_t;

  // Unsigned subtraction: an address below base wraps high and also fails the index test.
  function automatic logic req_err(input logic [31:0] addr, input logic [3:0] be,
                                   input logic [31:0] base, input int unsigned depth_log2);
    logic [31:0] off;
    off = addr - base;
    return (addr < base) || ((off >> (depth_log2 + 2)) != 32'd0) || (be == 4'b0000);
  endfunction

endpackage

// File: rtl/dm_bus_responder_if.sv
// Core data-bus handshake: request channel (core -> memory) and response channel (memory -> core).
interface dm_bus_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_bus_responder_ram.sv
// Word-organised data RAM: per-lane synchronous write, registered synchronous read, no reset.
module dm_ram #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [0:(1 << DEPTH_LOG2) - 1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_bus_responder.sv
// Memory-side responder for the core data bus: one outstanding request, WAIT_CYCLES wait states,
// range/byte-enable error check, RAM touched only on the cycle that enters RESP.
import dm_bus_responder_pkg::*;

module dm_bus_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  dm_bus_responder_if.slave bus_io
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  req_t                  req_q, req_d, req_in, cur;
  logic                  accept, enter_resp, ram_we, ram_re;
  logic                  req_ready, rsp_valid, rsp_err;
  logic [31:0]           rsp_rdata, cur_off, ram_rdata;
  logic [DEPTH_LOG2-1:0] ram_idx;

  always_comb begin
    req_in.we    = bus_io.req_we;
    req_in.addr  = bus_io.req_addr;
    req_in.be    = bus_io.req_be;
    req_in.wdata = bus_io.req_wdata;
    req_in.err   = req_err(bus_io.req_addr, bus_io.req_be, BASE_ADDR, DEPTH_LOG2);
  end

  // With zero wait states the RAM is driven straight from the bus in the accept cycle.
  assign cur     = (state_q == ST_IDLE) ? req_in : req_q;
  assign accept  = bus_io.req_valid & req_ready;
  assign cur_off = cur.addr - BASE_ADDR;
  assign ram_idx = DEPTH_LOG2'(cur_off >> 2);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d = req_in;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RESP: begin
        if (bus_io.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE) & rst_ni;
    rsp_valid  = (state_q == ST_RESP);
    rsp_err    = rsp_valid & req_q.err;
    rsp_rdata  = (rsp_valid & ~req_q.we & ~req_q.err) ? ram_rdata : 32'd0;
    enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    ram_we     = enter_resp & cur.we & ~cur.err;
    ram_re     = enter_resp & ~cur.we & ~cur.err;
  end

  assign bus_io.req_ready = req_ready;
  assign bus_io.rsp_valid = rsp_valid;
  assign bus_io.rsp_err   = rsp_err;
  assign bus_io.rsp_rdata = rsp_rdata;

  dm_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_idx),
    .be_i    (cur.be),
    .wdata_i (cur.wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_dm_bus_responder.sv
// Directed bench: main function on a 1-wait-state build, throughput/latency on 0- and 15-wait builds.
import dm_bus_responder_pkg::*;

module tb_dm_bus_responder;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_bus_responder_if bus1();
  dm_bus_responder_if bus0();
  dm_bus_responder_if bus15();

  dm_bus_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_w1 (
    .clk_i(clk), .rst_ni(rst_n), .bus_io(bus1));
  dm_bus_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_w0 (
    .clk_i(clk), .rst_ni(rst_n), .bus_io(bus0));
  dm_bus_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(15), .BASE_ADDR(32'h0)) u_w15 (
    .clk_i(clk), .rst_ni(rst_n), .bus_io(bus15));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output int t_a);
    int n = 0;
    bus1.req_valid = 1'b1;
    bus1.req_we    = we;
    bus1.req_addr  = addr;
    bus1.req_be    = be;
    bus1.req_wdata = wd;
    #1;
    while (!bus1.req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("req_ready_seen", 64'(bus1.req_ready), 64'd1);
    t_a = cyc;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    bus1.req_addr  = 32'hFFFF_FFF0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!bus1.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_seen", 64'(bus1.rsp_valid), 64'd1);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int t_a;
    issue(we, addr, be, wd, t_a);
    wait_rsp();
    lat = cyc - t_a;
    rd  = bus1.rsp_rdata;
    er  = bus1.rsp_err;
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
  endtask

  int acc_c [2][4];
  int rise_c[2][4];
  int n_acc [2];
  int n_rise[2];
  logic prev_v[2];

  task automatic note(input int d, input logic acc, input logic vld);
    if (acc && n_acc[d] < 4) begin
      acc_c[d][n_acc[d]] = cyc;
      n_acc[d]++;
    end
    if (vld && !prev_v[d] && n_rise[d] < 4) begin
      rise_c[d][n_rise[d]] = cyc;
      n_rise[d]++;
    end
    prev_v[d] = vld;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, t_a;

  initial begin
    rst_n = 1'b0;
    bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = 0; bus1.req_be = 0;
    bus1.req_wdata = 0; bus1.rsp_ready = 0;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_be = 0;
    bus0.req_wdata = 0; bus0.rsp_ready = 0;
    bus15.req_valid = 0; bus15.req_we = 0; bus15.req_addr = 0; bus15.req_be = 0;
    bus15.req_wdata = 0; bus15.rsp_ready = 0;
    for (int d = 0; d < 2; d++) begin
      n_acc[d] = 0; n_rise[d] = 0; prev_v[d] = 1'b0;
    end

    // Reset state
    #1;
    bus1.req_valid = 1'b1;
    chk("rst_req_ready", 64'(bus1.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus1.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(bus1.rsp_rdata), 64'd0);
    chk("rst_rsp_err",   64'(bus1.rsp_err),   64'd0);
    repeat (3) @(negedge clk);
    bus1.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready", 64'(bus1.req_ready), 64'd1);
    @(negedge clk);

    // Store / load word, latency
    xact(1'b1, 32'h10, BE_WORD, 32'hDEADBEEF, rd, er, lat);
    chk("st_lat", 64'(lat), 64'd2);
    chk("st_err", 64'(er), 64'd0);
    chk("st_rdata", 64'(rd), 64'd0);
    xact(1'b0, 32'h10, BE_WORD, 32'h0, rd, er, lat);
    chk("ld_lat", 64'(lat), 64'd2);
    chk("ld_word", 64'({er, rd}), 64'({1'b0, 32'hDEADBEEF}));

    // Byte lanes
    xact(1'b1, 32'h10, BE_B2, 32'h00AA0000, rd, er, lat);
    xact(1'b0, 32'h10, BE_WORD, 32'h0, rd, er, lat);
    chk("lane_b2", 64'({er, rd}), 64'({1'b0, 32'hDEAABEEF}));
    xact(1'b1, 32'h10, BE_HALF0, 32'h00001234, rd, er, lat);
    xact(1'b0, 32'h10, BE_WORD, 32'h0, rd, er, lat);
    chk("lane_h0", 64'({er, rd}), 64'({1'b0, 32'hDEAA1234}));

    // Range
    xact(1'b1, 32'h0, BE_WORD, 32'h11111111, rd, er, lat);
    xact(1'b1, 32'hFFC, BE_WORD, 32'h0BADF00D, rd, er, lat);
    chk("top_st_err", 64'(er), 64'd0);
    xact(1'b0, 32'hFFC, BE_WORD, 32'h0, rd, er, lat);
    chk("top_ld", 64'({er, rd}), 64'({1'b0, 32'h0BADF00D}));
    xact(1'b0, 32'h1000, BE_WORD, 32'h0, rd, er, lat);
    chk("oor_ld", 64'({er, rd}), 64'({1'b1, 32'h0}));
    chk("oor_lat", 64'(lat), 64'd2);
    xact(1'b1, 32'h1000, BE_WORD, 32'h55555555, rd, er, lat);
    chk("oor_st", 64'({er, rd}), 64'({1'b1, 32'h0}));
    xact(1'b0, 32'h0, BE_WORD, 32'h0, rd, er, lat);
    chk("no_alias", 64'({er, rd}), 64'({1'b0, 32'h11111111}));
    xact(1'b0, 32'h10, 4'b0000, 32'h0, rd, er, lat);
    chk("be0_ld", 64'({er, rd}), 64'({1'b1, 32'h0}));
    xact(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, rd, er, lat);
    chk("be0_st", 64'(er), 64'd1);

    // Backpressure with junk requests on the bus
    issue(1'b0, 32'h10, BE_WORD, 32'h0, t_a);
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      bus1.req_valid = 1'b1;
      bus1.req_we    = 1'b1;
      bus1.req_addr  = 32'h10;
      bus1.req_be    = BE_WORD;
      bus1.req_wdata = 32'hA5A5_0000 + 32'(k);
      #1;
      chk("bp_hold", 64'({bus1.rsp_valid, bus1.req_ready, bus1.rsp_err, bus1.rsp_rdata}),
          64'({1'b1, 1'b0, 1'b0, 32'hDEAA1234}));
      @(negedge clk);
    end
    bus1.req_valid = 1'b0;
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    #1;
    chk("bp_idle", 64'({bus1.req_ready, bus1.rsp_valid}), 64'({1'b1, 1'b0}));
    xact(1'b0, 32'h10, BE_WORD, 32'h0, rd, er, lat);
    chk("bp_nowrite", 64'(rd), 64'(32'hDEAA1234));

    // Reset mid-WAIT drops the pending store
    issue(1'b1, 32'h10, BE_WORD, 32'hCAFEF00D, t_a);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst", 64'({bus1.rsp_valid, bus1.req_ready}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("midwait_ready", 64'(bus1.req_ready), 64'd1);
    xact(1'b0, 32'h10, BE_WORD, 32'h0, rd, er, lat);
    chk("midwait_old", 64'({er, rd}), 64'({1'b0, 32'hDEAA1234}));

    // Reset in RESP keeps the already-written store
    issue(1'b1, 32'h20, BE_WORD, 32'h00000077, t_a);
    wait_rsp();
    rst_n = 1'b0;
    #1;
    chk("resp_rst", 64'({bus1.rsp_valid, bus1.rsp_err, bus1.rsp_rdata}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xact(1'b0, 32'h20, BE_WORD, 32'h0, rd, er, lat);
    chk("resp_kept", 64'({er, rd}), 64'({1'b0, 32'h00000077}));

    // Throughput / latency with req_valid and rsp_ready held high
    bus0.req_valid = 1'b1;  bus0.req_addr = 32'h20;  bus0.req_be = BE_WORD;  bus0.rsp_ready = 1'b1;
    bus15.req_valid = 1'b1; bus15.req_addr = 32'h20; bus15.req_be = BE_WORD; bus15.rsp_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      #1;
      note(0, bus0.req_valid & bus0.req_ready, bus0.rsp_valid);
      note(1, bus15.req_valid & bus15.req_ready, bus15.rsp_valid);
      @(negedge clk);
    end
    bus0.req_valid = 1'b0;
    bus15.req_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      int w;
      w = (d == 0) ? 0 : 15;
      chk($sformatf("w%0d_nacc", w), 64'(n_acc[d] >= 3), 64'd1);
      chk($sformatf("w%0d_nrise", w), 64'(n_rise[d] >= 3), 64'd1);
      for (int k = 1; k < 3; k++)
        chk($sformatf("w%0d_spacing%0d", w, k), 64'(acc_c[d][k] - acc_c[d][k-1]), 64'(w + 2));
      for (int k = 0; k < 3; k++)
        chk($sformatf("w%0d_lat%0d", w, k), 64'(rise_c[d][k] - acc_c[d][k]), 64'(w + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
